riscv_button_event_gen: RTL

RISCV_BUTTON_EVENT_GEN -- requirements
Module: riscv_button_event_gen

---
 rtl/riscv_button_event_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/riscv_button_event_gen.sv
// riscv_button_event_gen
// Turns a clean, clk-synchronous button level into press / release / long-press
// / auto-repeat event pulses, a "held" level and a modulo-256 press counter.
// Every output is a register; nothing combinational reaches a port.
//
// Optional feature: define RISCV_BTN_AUTOREPEAT_EN to enable auto-repeat pulses
// while a long press is held. Without it repeat_pulse stays 0 and the timer
// freezes once the long press has been reported.
//
// A button already held when reset releases must be seen low once (WAIT_LOW)
// before a press can be accepted, so reset never manufactures a press event.

module riscv_button_event_gen #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debounced,
    input  logic       count_clr,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    // The timer only ever counts up to (terminal count - 1), so $clog2 of the
    // larger period is always wide enough to hold it without overflow.
    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES);

    localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYCLES - 1);
`ifdef RISCV_BTN_AUTOREPEAT_EN
    localparam logic [TW-1:0] REPEAT_TC = TW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;

    logic       press_next;
    logic       release_next;
    logic       long_next;
    logic       repeat_next;
    logic       held_next;
    logic [7:0] count_next;

    // State register: state, timer, and the registered copies of every output.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_LOW;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= held_next;
            press_count   <= count_next;
        end
    end

    // Next-state and timer logic; release always wins over a terminal count.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_next = state;
        timer_next = timer;
        case (state)
            WAIT_LOW: begin
                if (!debounced) state_next = IDLE;
            end
            IDLE: begin
                if (debounced) begin
                    state_next = PRESSED;
                    timer_next = '0;
                end
            end
            PRESSED: begin
                if (!debounced) begin
                    state_next = IDLE;
                end else if (timer == LONG_TC) begin
                    state_next = LONG;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            LONG: begin
                if (!debounced) begin
                    state_next = IDLE;
`ifdef RISCV_BTN_AUTOREPEAT_EN
                end else if (timer == REPEAT_TC) begin
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
`endif
                end
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    // Output decode: values the output registers take on the coming edge.
    always_comb begin
        press_next   = (state == IDLE) && debounced;
        release_next = ((state == PRESSED) || (state == LONG)) && !debounced;
        long_next    = (state == PRESSED) && debounced && (timer == LONG_TC);
`ifdef RISCV_BTN_AUTOREPEAT_EN
        repeat_next  = (state == LONG) && debounced && (timer == REPEAT_TC);
`else
        repeat_next  = 1'b0;
`endif
        held_next    = (state_next == PRESSED) || (state_next == LONG);
        if (count_clr) begin
            count_next = 8'd0;
        end else if (press_next) begin
            count_next = press_count + 8'd1;
        end else begin
            count_next = press_count;
        end
    end

endmodule
